// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: IDLE -> FETCH -> ISSUE loop with branch/jump PC steering and a fetch timeout.
// Optional INSTR_COUNT_EN macro adds o_inst_count, a wrapping count of consumed instructions.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [5:0]  o_opcode,
  output logic [5:0]  o_func,
  output logic        o_inst_valid,
  input  logic        i_halted,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_jump_register,
  input  logic        i_link,
  input  logic        i_branch_cond,
  input  logic [31:0] i_rs_data,
  input  logic        i_stall,
  output logic [31:0] o_pc,
  output logic [31:0] o_link_addr,
  output logic        o_halt_out,
  output logic        o_fault
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0] o_inst_count
`endif
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_pc, r_inst;
  logic [WW-1:0] r_wait;
  logic          r_fault;

  logic [31:0]   w_pc4, w_br_off, w_next_pc;
  logic          w_issue_go, w_timeout;
  logic          w_unused;

  assign w_unused   = ^i_rs_data[1:0];
  assign w_issue_go = (r_state == S_ISSUE) && !i_stall;
  assign w_timeout  = (r_state == S_FETCH) && !i_imem_ready && (r_wait == WAIT_LAST);

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc4;
    if (i_jump_register)              w_next_pc = {i_rs_data[31:2], 2'b00};
    else if (i_jump)                  w_next_pc = {w_pc4[31:28], r_inst[25:0], 2'b00};
    else if (i_branch && i_branch_cond) w_next_pc = w_pc4 + w_br_off;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_FETCH;
      S_FETCH: begin
        if (i_imem_ready)   w_next = S_ISSUE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_ISSUE: begin
        if (!i_stall) w_next = i_halted ? S_HALT : S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= 32'd0;
      r_wait  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        if (i_imem_ready) begin
          r_inst <= i_imem_rdata;
          r_wait <= '0;
        end else if (!w_timeout) begin
          r_wait <= r_wait + 1'b1;
        end
      end
      if (w_timeout) r_fault <= 1'b1;
      // A halting instruction keeps its own pc visible.
      if (w_issue_go && !i_halted) r_pc <= w_next_pc;
    end
  end

  assign o_imem_req   = (r_state == S_FETCH);
  assign o_imem_addr  = r_pc;
  assign o_inst_valid = (r_state == S_ISSUE);
  assign o_halt_out   = (r_state == S_HALT);
  assign o_fault      = r_fault;
  assign o_inst       = r_inst;
  assign o_opcode     = r_inst[31:26];
  assign o_func       = r_inst[5:0];
  assign o_pc         = r_pc;
  assign o_link_addr  = i_link ? (r_pc + 32'd8) : 32'd0;

`ifdef INSTR_COUNT_EN
  logic [31:0] r_inst_count;
  always_ff @(posedge i_clk) begin
    if (i_rst)           r_inst_count <= 32'd0;
    else if (w_issue_go) r_inst_count <= r_inst_count + 32'd1;
  end
  assign o_inst_count = r_inst_count;
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter WAIT_LIMIT, 16, imem_ready timeout in cycles before the fault halt.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  instruction-memory read request.
REQ-006 imem_addr  out  32  word-aligned fetch address (= pc).
REQ-007 imem_ready  in  1  read data valid this cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 inst  out  32  held instruction; opcode out 6 = inst[31:26]; func out 6 = inst[5:0].
REQ-010 inst_valid  out  1  inst/opcode/func valid for decode; decoder outputs consumed this cycle.
REQ-011 halted, branch, jump, jump_register, link  in  1 each  decoded control signals for the issued instruction.
REQ-012 branch_cond  in  1  branch comparison result; rs_data  in  32  jump-register target.
REQ-013 stall  in  1  back-pressure from the datapath.
REQ-014 pc  out  32  address of the issued instruction; link_addr  out  32  = pc+8 when link=1, else 0.
REQ-015 halt_out  out  1  sequencer halted; fault  out  1  fetch timed out.

Function
REQ-016 States SHALL be IDLE, FETCH, ISSUE, HALT.
REQ-017 IDLE -> FETCH unconditionally one cycle after reset is released.
REQ-018 FETCH: imem_req=1 and imem_addr=pc; on imem_ready, latch imem_rdata into inst and go to ISSUE.
REQ-019 FETCH: wait counter increments every non-ready cycle; at WAIT_LIMIT, fault=1 and go to HALT.
REQ-020 ISSUE: inst_valid=1; with stall=1, stay in ISSUE with inst and pc held and no PC update.
REQ-021 ISSUE with stall=0 and halted=1: go to HALT; pc held.
REQ-022 ISSUE with stall=0 and halted=0: update pc and go to FETCH.
REQ-023 Next-pc priority (first match wins):
- jump_register -> {rs_data[31:2],2'b00}
- jump -> {pc4[31:28],inst[25:0],2'b00}
- branch&branch_cond -> pc4+(sext(inst[15:0])<<2)
- otherwise pc4, where pc4=pc+4.
REQ-024 All address arithmetic SHALL be 32-bit modulo 2^32; pc 32'hFFFF_FFFC advances to 0.
REQ-025 HALT SHALL be absorbing until rst; halt_out=1, imem_req=0, inst_valid=0.
REQ-026 inst_valid and imem_req SHALL never be high in the same cycle.
REQ-027 imem_ready outside FETCH SHALL be ignored.

Reset
REQ-028 rst=1 at a clock edge in any state, including mid-FETCH: state=IDLE, pc=RESET_PC, inst=0, wait counter=0.
REQ-029 Outputs during and one cycle after reset: inst_valid=0, imem_req=0, halt_out=0, fault=0.

Configuration
REQ-030 Macro INSTR_COUNT_EN defined: adds output inst_count (out, 32), a counter reset to 0 that increments on each ISSUE cycle with stall=0, including the halting instruction, and wraps at 2^32.
REQ-031 INSTR_COUNT_EN undefined: no inst_count port and no counter logic.

Verification
REQ-032 Reset then imem_ready=1 each FETCH with ADDIU words -> pc sequence 0,4,8; inst_valid every second cycle.
REQ-033 Branch at pc=0x10, imm=16'hFFFF, branch=1, branch_cond=1 -> next imem_addr=0x10; with branch_cond=0 -> 0x14.
REQ-034 jump_register=1 and jump=1 together, rs_data=0x0000_0103 -> next imem_addr=0x0000_0100.
REQ-035 stall=1 for 3 ISSUE cycles -> inst/pc stable and no imem_req; with link=1 at pc=0x20 -> link_addr=0x28.
REQ-036 halted=1 in ISSUE -> halt_out=1 the next cycle, stays high; imem_ready held low 16 cycles in FETCH -> fault=1, HALT.
REQ-037 rst asserted mid-FETCH -> IDLE, pc=RESET_PC; under INSTR_COUNT_EN, 5 issues -> inst_count=5.
